// File: rtl/duty_ramp.sv
// duty_ramp: slew-limited duty setpoint generator feeding the pwm stage.
// Accepts a target over valid/ready, saturates it to PERIOD, then walks the
// duty output toward it by at most STEP counts, updating only at frame ends.
module duty_ramp #(
  parameter int unsigned PERIOD = 195,
  parameter int unsigned DIV    = 4,
  parameter int unsigned STEP   = 4
) (
  input  logic        clock_50,
  input  logic        clr,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_duty,
  output logic        cmd_ready,
  output logic [15:0] duty,
  output logic        busy,
  output logic        done,
  output logic        frame_tick
);

  localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD - 1);
  localparam logic [15:0]     DutyMax = 16'(PERIOD);
  localparam logic [16:0]     Step17  = 17'(STEP);
  localparam logic [15:0]     Step16  = 16'(STEP);

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q;
  logic [CntW-1:0] cnt_q;
  logic            frame_end;
  logic            tick_q;
  logic [15:0]     duty_q, duty_d;
  logic [15:0]     tgt_q, tgt_d;
  logic [15:0]     tgt_sat;
  logic [16:0]     up_diff, dn_diff;
  logic            done_q, done_d;
  logic            ready_q, busy_q;
  logic            accept;

  // Frame boundary is the last prescaler phase of the last count.
  assign frame_end = (pre_q == PreLast) && (cnt_q == CntLast);
  assign tgt_sat   = (cmd_duty > DutyMax) ? DutyMax : cmd_duty;
  // 17-bit differences; only the one matching the ramp direction is used.
  assign up_diff   = {1'b0, tgt_q} - {1'b0, duty_q};
  assign dn_diff   = {1'b0, duty_q} - {1'b0, tgt_q};
  assign accept    = cmd_valid & ready_q;

  assign cmd_ready  = ready_q;
  assign duty       = duty_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_tick = tick_q;

  // Free-running prescaler and PWM count, mirroring the pwm divider.
  always_ff @(posedge clock_50) begin
    if (clr) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= frame_end;
      if (pre_q == PreLast) begin
        pre_q <= '0;
        cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  // Ramp state, duty and handshake registers.
  always_ff @(posedge clock_50) begin
    if (clr) begin
      state_q <= StIdle;
      duty_q  <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      ready_q <= (state_d == StIdle);
      busy_q  <= (state_d != StIdle);
    end
  end

  // Next-state: capture in idle, one bounded step per frame while ramping.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // Idle never steps, so a command landing on a boundary waits a frame.
        if (accept) begin
          tgt_d = tgt_sat;
          if (tgt_sat > duty_q) begin
            state_d = StUp;
          end else if (tgt_sat < duty_q) begin
            state_d = StDown;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StUp: begin
        if (frame_end) begin
          if (up_diff <= Step17) begin
            duty_d  = tgt_q;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            duty_d = duty_q + Step16;
          end
        end
      end
      StDown: begin
        if (frame_end) begin
          if (dn_diff <= Step17) begin
            duty_d  = tgt_q;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            duty_d = duty_q - Step16;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule
